jtcop_obj_linebuf: RTL and testbench

// Double-buffered object line buffer; the stage directly upstream of the colour mixer.
// The object engine draws next line's pixels into the write bank while the read bank
// is scanned by hdump and sent out as obj_pxl (MCOL) to the mixer.

---
 rtl/jtcop_obj_linebuf.sv | 208 ++++++++++++++++++++
 tb/tb_jtcop_obj_linebuf.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/jtcop_obj_linebuf.sv
// ---------------------------------------------------------------------------
// jtcop_obj_linebuf
// Double-buffered object line buffer feeding the colour mixer.
// The object engine draws the next line into the write bank while the read
// bank is scanned by hdump and sent out as obj_pxl. The banks swap on every
// LHBL falling edge, and each pixel is erased on the clk after it is read.
//
// Build option: JTCOP_LBUF_PRIO_EN
//   defined   - first opaque pixel wins (2-clk read-modify-write per draw)
//   undefined - last write wins (single-clk write, draw_ok stays high in RUN)
//
// Ports
//   clk        video clock
//   rst_n      asynchronous reset, active low
//   pxl_cen    pixel clock enable (>= 2 clk between pulses)
//   LHBL       horizontal blank, active low; falling edge swaps banks
//   hdump      read column
//   obj_en     0 forces obj_pxl to 0 (erase still runs)
//   draw_we    draw request, accepted when draw_ok=1
//   draw_addr  draw column in the write bank
//   draw_pxl   pixel to draw; [3:0]==0 is transparent
//   draw_ok    draw port ready
//   line_done  one-clk pulse on bank swap
//   obj_pxl    pixel to the colour mixer
// ---------------------------------------------------------------------------
module jtcop_obj_linebuf #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic [AW-1:0] hdump,
  input  logic          obj_en,
  input  logic          draw_we,
  input  logic [AW-1:0] draw_addr,
  input  logic [DW-1:0] draw_pxl,
  output logic          draw_ok,
  output logic          line_done,
  output logic [DW-1:0] obj_pxl
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          bank_reg;        // read bank; write bank is ~bank_reg
  logic          lhbl_reg;
  logic [AW-1:0] rd_addr_reg;
  logic          erase_pend_reg;
  logic          erase_bank_reg;
  logic [AW-1:0] erase_addr_reg;
  logic          swap;
  logic          accept;
  logic          draw_stall;

  logic [1:0][DW-1:0] scan_q;
  logic [DW-1:0]      q;

  // Draw write request, resolved per bank below
  logic          dw_en;
  logic          dw_bank;
  logic [AW-1:0] dw_addr;
  logic [DW-1:0] dw_data;

  assign swap   = lhbl_reg & ~LHBL;
  assign accept = draw_we & draw_ok;
  assign q      = scan_q[bank_reg];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    draw_ok    = 1'b0;
    case (state_reg)
      ST_INIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == {AW{1'b1}}) state_next = ST_RUN;
      end
      ST_RUN:  draw_ok = ~draw_stall;
      default: state_next = ST_INIT;
    endcase
  end

  // ---------------- bank swap and read path ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_reg       <= 1'b0;
      lhbl_reg       <= 1'b0;
      line_done      <= 1'b0;
      obj_pxl        <= '0;
      erase_pend_reg <= 1'b0;
      erase_bank_reg <= 1'b0;
      erase_addr_reg <= '0;
    end else begin
      lhbl_reg       <= LHBL;
      line_done      <= swap;
      erase_pend_reg <= pxl_cen;
      if (swap) bank_reg <= ~bank_reg;
      if (pxl_cen) begin
        obj_pxl        <= obj_en ? q : '0;
        // Remember which bank was read so the erase lands there even if a
        // swap happens on the very next edge.
        erase_bank_reg <= bank_reg;
        erase_addr_reg <= rd_addr_reg;
      end
    end
  end

  // Read address register kept reset-free so it folds into the RAM.
  always_ff @(posedge clk) begin
    rd_addr_reg <= hdump;
  end

  // ---------------- draw path ----------------
`ifdef JTCOP_LBUF_PRIO_EN
  logic               pend_reg;
  logic               pend_bank_reg;
  logic [AW-1:0]      pend_addr_reg;
  logic [DW-1:0]      pend_pxl_reg;
  logic [1:0][DW-1:0] rmw_q;
  logic [DW-1:0]      stored;

  assign stored     = rmw_q[pend_bank_reg];
  assign draw_stall = pend_reg;
  // Second clk of the read-modify-write: only fill transparent slots.
  assign dw_en      = pend_reg & (|pend_pxl_reg[3:0]) & ~(|stored[3:0]);
  assign dw_bank    = pend_bank_reg;
  assign dw_addr    = pend_addr_reg;
  assign dw_data    = pend_pxl_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg      <= 1'b0;
      pend_bank_reg <= 1'b0;
      pend_pxl_reg  <= '0;
    end else begin
      pend_reg <= accept;
      if (accept) begin
        pend_bank_reg <= ~bank_reg;
        pend_pxl_reg  <= draw_pxl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pend_addr_reg <= draw_addr;
  end
`else
  assign draw_stall = 1'b0;
  // Same-clk draw and swap: ~bank_reg is still the pre-swap write bank.
  assign dw_en      = accept & (|draw_pxl[3:0]);
  assign dw_bank    = ~bank_reg;
  assign dw_addr    = draw_addr;
  assign dw_data    = draw_pxl;
`endif

  // ---------------- RAM banks ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [DW-1:0] mem [0:2**AW-1];
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;

      // One write port per bank. The clear sweep owns both banks in INIT;
      // afterwards draw and erase normally hit opposite banks, with the draw
      // taking precedence in the rare overlap right after a swap.
      always_comb begin
        we = 1'b0;
        wa = erase_addr_reg;
        wd = '0;
        if (state_reg == ST_INIT) begin
          we = 1'b1;
          wa = cnt_reg;
        end else if (dw_en && (dw_bank == 1'(gi))) begin
          we = 1'b1;
          wa = dw_addr;
          wd = dw_data;
        end else if (erase_pend_reg && (erase_bank_reg == 1'(gi))) begin
          we = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
      end

      assign scan_q[gi] = mem[rd_addr_reg];
`ifdef JTCOP_LBUF_PRIO_EN
      assign rmw_q[gi]  = mem[pend_addr_reg];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_jtcop_obj_linebuf.sv
// ---------------------------------------------------------------------------
// tb_jtcop_obj_linebuf
// Directed bench for jtcop_obj_linebuf (AW=9, DW=8). Honours
// JTCOP_LBUF_PRIO_EN for the draw-priority expectations.
// ---------------------------------------------------------------------------
module tb_jtcop_obj_linebuf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b1;
  logic [8:0] hdump = '0;
  logic       obj_en = 1'b1;
  logic       draw_we = 1'b0;
  logic [8:0] draw_addr = '0;
  logic [7:0] draw_pxl = '0;
  logic       draw_ok;
  logic       line_done;
  logic [7:0] obj_pxl;

  logic [7:0] line_buf [0:511];
  int tests = 0;
  int fails = 0;

  jtcop_obj_linebuf #(.AW(9), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL),
    .hdump(hdump), .obj_en(obj_en), .draw_we(draw_we),
    .draw_addr(draw_addr), .draw_pxl(draw_pxl), .draw_ok(draw_ok),
    .line_done(line_done), .obj_pxl(obj_pxl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pixel period (2 clk): address registered, then pxl_cen captures it.
  task automatic pixel(input int h);
    hdump   = 9'(h);
    pxl_cen = 1'b0;
    tick();
    pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
  endtask

  task automatic scan();
    for (int h = 0; h < 512; h++) begin
      pixel(h);
      line_buf[h] = obj_pxl;
    end
  endtask

  function automatic int nonzero_except(input int col);
    int n = 0;
    for (int i = 0; i < 512; i++)
      if (i != col && line_buf[i] != 8'h00) n++;
    return n;
  endfunction

  task automatic swap();
    LHBL = 1'b0;
    tick();
    check("line_done_pulse", 32'(line_done), 1);
    LHBL = 1'b1;
    tick();
    check("line_done_end", 32'(line_done), 0);
  endtask

  task automatic wait_init();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!draw_ok && n < 2000);
    check("init_len", n, 512);
  endtask

  task automatic draw(input logic [8:0] a, input logic [7:0] p);
    int n = 0;
    while (!draw_ok && n < 100) begin
      tick();
      n++;
    end
    check("draw_ready", 32'(draw_ok), 1);
    draw_we   = 1'b1;
    draw_addr = a;
    draw_pxl  = p;
    tick();
    draw_we = 1'b0;
`ifdef JTCOP_LBUF_PRIO_EN
    check("draw_ok_after_accept", 32'(draw_ok), 0);
`else
    check("draw_ok_after_accept", 32'(draw_ok), 1);
`endif
  endtask

  initial begin
    // 1: reset state and INIT length, first line all zero
    repeat (3) tick();
    check("rst_obj_pxl", 32'(obj_pxl), 0);
    check("rst_draw_ok", 32'(draw_ok), 0);
    check("rst_line_done", 32'(line_done), 0);
    rst_n = 1'b1;
    wait_init();
    scan();
    check("first_line_nonzero", nonzero_except(-1), 0);

    // 2: draw col 10, read it back after one swap, erased two swaps later
    draw(9'd10, 8'h35);
    swap();
    scan();
    check("col10_drawn", 32'(line_buf[10]), 32'h35);
    check("col10_others", nonzero_except(10), 0);
    swap();
    swap();
    scan();
    check("col10_erased", 32'(line_buf[10]), 0);

    // 3: transparent draw writes nothing
    draw(9'd20, 8'h40);
    swap();
    scan();
    check("col20_transparent", 32'(line_buf[20]), 0);

    // 4: two draws on one column
    draw(9'd5, 8'h12);
    draw(9'd5, 8'h34);
    swap();
    scan();
`ifdef JTCOP_LBUF_PRIO_EN
    check("col5_priority", 32'(line_buf[5]), 32'h12);
`else
    check("col5_priority", 32'(line_buf[5]), 32'h34);
`endif

    // 5: draw on the same clk as the LHBL fall lands in the pre-swap bank
    check("same_clk_ready", 32'(draw_ok), 1);
    LHBL      = 1'b0;
    draw_we   = 1'b1;
    draw_addr = 9'd7;
    draw_pxl  = 8'h21;
    tick();
    draw_we = 1'b0;
    check("same_clk_line_done", 32'(line_done), 1);
    LHBL = 1'b1;
    tick();
    scan();
    check("col7_same_clk", 32'(line_buf[7]), 32'h21);
    check("col7_others", nonzero_except(7), 0);

    // 6: obj_en=0 hides output but still erases
    draw(9'd3, 8'h55);
    swap();
    obj_en = 1'b0;
    scan();
    check("obj_en_off", nonzero_except(-1), 0);
    obj_en = 1'b1;
    swap();
    swap();
    scan();
    check("col3_erased_disabled", 32'(line_buf[3]), 0);

    // 7: asynchronous reset mid-scan, INIT re-clears the RAM
    draw(9'd3, 8'h66);
    swap();
    for (int h = 0; h < 4; h++) pixel(h);
    check("mid_scan_pixel", 32'(obj_pxl), 32'h66);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_obj_pxl", 32'(obj_pxl), 0);
    check("async_rst_draw_ok", 32'(draw_ok), 0);
    tick();
    rst_n = 1'b1;
    wait_init();
    scan();
    check("post_reset_line", nonzero_except(-1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
